// File: rtl/oser8_tx.sv
// 8:1 fabric serializer: byte-wide valid/ready input, double-buffered, one bit per clk on d_o.
// Emits a first-bit strobe and a byte-rate clock for IDES8 loopback alignment.
module oser8_tx #(
   parameter bit   LSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       d_o,
   output logic       frame_o,
   output logic       pclk_o,
   output logic       underrun_o
);

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state;
   logic [W-1:0]  hold;
   logic          hold_full;
   logic [W-1:0]  shreg;
   logic [CW-1:0] cnt;

   logic          accept_c;
   logic          last_c;
   logic          load_c;
   logic          first_bit_c;
   logic          next_bit_c;
   logic [W-1:0]  load_shreg_c;
   logic [W-1:0]  next_shreg_c;
   logic [CW-1:0] cnt_inc_c;

   assign ready_o  = rst_i & ~hold_full;
   assign accept_c = valid_i & ready_o;
   assign last_c   = (state == SHIFT) && (cnt == CW'(W - 1));
   // Accept needs hold empty and load needs hold full, so the two never coincide.
   assign load_c   = hold_full && ((state == IDLE) || last_c);

   assign first_bit_c  = LSB_FIRST ? hold[0]  : hold[W-1];
   assign load_shreg_c = LSB_FIRST ? (hold >> 1)  : (hold << 1);
   assign next_bit_c   = LSB_FIRST ? shreg[0] : shreg[W-1];
   assign next_shreg_c = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
   assign cnt_inc_c    = cnt + CW'(1);

   // Holding register: the second half of the double buffer.
   always_ff @(posedge clk) begin
      if (!rst_i) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (accept_c) begin
         hold      <= data_i;
         hold_full <= 1'b1;
      end else if (load_c) begin
         hold_full <= 1'b0;
      end
   end

   // Shift FSM with registered serial outputs.
   always_ff @(posedge clk) begin
      if (!rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         d_o        <= IDLE_BIT;
         frame_o    <= 1'b0;
         pclk_o     <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         frame_o    <= 1'b0;
         underrun_o <= 1'b0;
         if (load_c) begin
            state   <= SHIFT;
            shreg   <= load_shreg_c;
            d_o     <= first_bit_c;
            cnt     <= '0;
            frame_o <= 1'b1;
            pclk_o  <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  d_o    <= IDLE_BIT;
                  cnt    <= '0;
                  pclk_o <= 1'b0;
               end
               SHIFT: begin
                  if (last_c) begin
                     state      <= IDLE;
                     d_o        <= IDLE_BIT;
                     cnt        <= '0;
                     pclk_o     <= 1'b0;
                     underrun_o <= 1'b1;
                  end else begin
                     d_o    <= next_bit_c;
                     shreg  <= next_shreg_c;
                     cnt    <= cnt_inc_c;
                     pclk_o <= ~cnt_inc_c[CW-1];
                  end
               end
               default: begin
                  state  <= IDLE;
                  d_o    <= IDLE_BIT;
                  cnt    <= '0;
                  pclk_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oser8_tx.sv
// Bench for oser8_tx: expected bytes queued on accept, a deserializing monitor pops and compares.
// Directed per-cycle vectors cover latency, bit order, idle level, and reset mid-byte.
`timescale 1ns/1ps
module tb_oser8_tx;

   logic       clk;
   logic       rst;

   logic [7:0] data;
   logic       valid;
   logic       ready, dout, frame, pclk, under;

   logic [7:0] data1;
   logic       valid1;
   logic       ready1, d1, frame1, pclk1, under1;

   logic [7:0] data2;
   logic       valid2;
   logic       ready2, d2, frame2, pclk2, under2;

   int         n_vec = 0;
   int         n_bad = 0;
   int         n_under = 0;

   logic [7:0] exp_q[$];
   bit         collecting = 0;
   bit         just_ended = 0;
   int         bitpos = 0;
   logic [7:0] rx;

   oser8_tx u_lsb (
      .clk(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
      .d_o(dout), .frame_o(frame), .pclk_o(pclk), .underrun_o(under)
   );

   oser8_tx #(.LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_i(rst), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
      .d_o(d1), .frame_o(frame1), .pclk_o(pclk1), .underrun_o(under1)
   );

   oser8_tx #(.IDLE_BIT(1'b1)) u_idle1 (
      .clk(clk), .rst_i(rst), .data_i(data2), .valid_i(valid2), .ready_o(ready2),
      .d_o(d2), .frame_o(frame2), .pclk_o(pclk2), .underrun_o(under2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Deserializing monitor on the LSB-first instance.
   always @(negedge clk) begin
      if (!rst) begin
         collecting = 0;
         just_ended = 0;
         exp_q.delete();
      end else begin
         if (under) n_under++;
         if (just_ended) begin
            chk("mon_underrun_at_end", under, !frame);
            just_ended = 0;
         end else begin
            chk("mon_no_underrun", under, 0);
         end
         if (frame) begin
            chk("mon_frame_mid_byte", collecting, 0);
            collecting = 1;
            bitpos = 0;
         end
         if (collecting) begin
            chk("mon_pclk", pclk, (bitpos < 4) ? 1 : 0);
            rx[bitpos] = dout;
            bitpos++;
            if (bitpos == 8) begin
               collecting = 0;
               just_ended = 1;
               if (exp_q.size() == 0) begin
                  chk("mon_unexpected_byte", rx, 32'hFFFF_FFFF);
               end else begin
                  chk("mon_byte", rx, exp_q.pop_front());
               end
            end
         end else begin
            chk("mon_idle_d", dout, 0);
            chk("mon_idle_pclk", pclk, 0);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int t = 0;
      valid = 1'b1;
      data  = b;
      while (!ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!ready) begin
         chk("send_ready_timeout", ready, 1);
      end else begin
         @(posedge clk);
         exp_q.push_back(b);
         #1;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || collecting || just_ended) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [7:0] seq_d, seq_p;
      logic [7:0] msb_in  [2];
      logic [7:0] msb_seq [2];
      int u0;

      msb_in[0]  = 8'h81; msb_seq[0] = 8'b1000_0001;
      msb_in[1]  = 8'h12; msb_seq[1] = 8'b0100_1000;

      rst = 1'b0;
      valid = 1'b0; data = 8'h00;
      valid1 = 1'b0; data1 = 8'h00;
      valid2 = 1'b0; data2 = 8'h00;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_d", dout, 0);
      chk("rst_frame", frame, 0);
      chk("rst_pclk", pclk, 0);
      chk("rst_underrun", under, 0);
      chk("rst_idle1_d", d2, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rel_ready", ready, 1);
      chk("rel_ready_msb", ready1, 1);

      // idle level on IDLE_BIT=1 instance
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("idle1_d", d2, 1);
         chk("idle1_pclk", pclk2, 0);
         chk("idle1_ready", ready2, 1);
      end

      // single byte 0xA5, LSB first
      seq_d = 8'b1010_0101;
      seq_p = 8'b0000_1111;
      @(posedge clk); #1;
      valid = 1'b1; data = 8'hA5;
      @(posedge clk);
      exp_q.push_back(8'hA5);
      #1;
      valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); @(negedge clk);
         if (k <= 8) begin
            chk("single_d", dout, seq_d[k-1]);
            chk("single_pclk", pclk, seq_p[k-1]);
         end else begin
            chk("single_d_idle", dout, 0);
            chk("single_pclk_idle", pclk, 0);
         end
         chk("single_frame", frame, (k == 1) ? 1 : 0);
         chk("single_underrun", under, (k == 9) ? 1 : 0);
      end
      drain();

      // back-to-back 0x3C, 0xC3 with valid held high
      u0 = n_under;
      @(posedge clk); #1;
      valid = 1'b1; data = 8'h3C;
      @(posedge clk);
      exp_q.push_back(8'h3C);
      #1;
      chk("b2b_ready_after_accept", ready, 0);
      data = 8'hC3;
      @(posedge clk); #1;
      chk("b2b_ready_after_load", ready, 1);
      @(posedge clk);
      exp_q.push_back(8'hC3);
      #1;
      valid = 1'b0;
      chk("b2b_ready_after_accept2", ready, 0);
      for (int k = 3; k <= 8; k++) begin
         @(posedge clk); #1;
         chk("b2b_ready_held_low", ready, 0);
      end
      @(posedge clk); #1;
      chk("b2b_ready_after_load2", ready, 1);
      drain();
      chk("b2b_single_underrun", n_under - u0, 1);

      // MSB first instance
      for (int b = 0; b < 2; b++) begin
         @(posedge clk); #1;
         chk("msb_ready", ready1, 1);
         valid1 = 1'b1; data1 = msb_in[b];
         @(posedge clk); #1;
         valid1 = 1'b0;
         seq_d = msb_seq[b];
         for (int k = 1; k <= 9; k++) begin
            @(posedge clk); @(negedge clk);
            chk("msb_d", d1, (k <= 8) ? seq_d[k-1] : 1'b0);
            chk("msb_frame", frame1, (k == 1) ? 1 : 0);
            chk("msb_underrun", under1, (k == 9) ? 1 : 0);
         end
      end

      // reset mid-byte: 0xFF in flight, 0x55 buffered
      @(posedge clk); #1;
      valid = 1'b1; data = 8'hFF;
      @(posedge clk);
      exp_q.push_back(8'hFF);
      #1;
      data = 8'h55;
      @(posedge clk); #1;
      @(posedge clk);
      exp_q.push_back(8'h55);
      #1;
      valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_bit3", dout, 1);
      @(posedge clk); @(negedge clk);
      chk("rstmid_d_idle", dout, 0);
      chk("rstmid_ready_low", ready, 0);
      chk("rstmid_frame", frame, 0);
      chk("rstmid_pclk", pclk, 0);
      chk("rstmid_underrun", under, 0);
      chk("rstmid_idle1_ready", ready2, 0);
      chk("rstmid_idle1_d", d2, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_ready_release", ready, 1);
      chk("rstmid_d_after", dout, 0);
      seq_d = 8'b0000_1111;
      valid = 1'b1; data = 8'h0F;
      @(posedge clk);
      exp_q.push_back(8'h0F);
      #1;
      valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); @(negedge clk);
         chk("rstmid_new_d", dout, seq_d[k-1]);
         chk("rstmid_new_frame", frame, (k == 1) ? 1 : 0);
      end
      drain();

      // loopback: 256 incrementing bytes streamed
      u0 = n_under;
      for (int i = 0; i < 256; i++) begin
         send(8'(i));
      end
      valid = 1'b0;
      drain();
      chk("loop_one_underrun_at_end", n_under - u0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/oser8_tx.md
# oser8_tx

Fabric 8:1 serializer: the transmit-side counterpart of the IDES8 deserializer examples. Accepts bytes over a valid/ready handshake, double-buffers them, and shifts them out one bit per `clk` on `d_o` with no gaps between back-to-back bytes. Emits a byte-rate clock (`pclk_o`) and a first-bit strobe (`frame_o`) so an IDES8 receiver on the board can be looped back and word-aligned.

## Interface
- `LSB_FIRST`, default 1: 1 = bit 0 sent first; 0 = bit 7 sent first.
- `IDLE_BIT`, default 1'b0: level driven on `d_o` when no byte is in flight.

Ports:
- `clk`  in  1  serial bit clock; one bit per rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `data_i`  in  8  byte to transmit.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a byte this cycle.
- `d_o`  out  1  serial data, registered.
- `frame_o`  out  1  high for the cycle `d_o` carries the first bit of a byte.
- `pclk_o`  out  1  byte-rate clock: high for bits 0-3, low for bits 4-7 of each byte; low when idle.
- `underrun_o`  out  1  one-cycle pulse: a byte ended with no next byte buffered.

## Operation
- Storage: 8-bit holding register `hold` plus `hold_full` flag; 8-bit shift register; 3-bit bit counter `cnt`; state `IDLE`/`SHIFT`.
- `ready_o = rst_i & ~hold_full` (combinational). Accept = `valid_i & ready_o` at a rising edge; accepting loads `hold` and sets `hold_full`.
- IDLE: `d_o = IDLE_BIT`, `cnt = 0`. On an edge with `hold_full = 1`: move `hold` into the shift register, clear `hold_full`, drive `d_o` with the first bit, set `cnt = 0`, go to SHIFT.
- SHIFT, `cnt < 7`: drive the next bit on `d_o`, `cnt += 1`.
- SHIFT, `cnt == 7`:
  - If `hold_full`: load the next byte as in IDLE. The first bit follows bit 7 with no idle cycle.
  - Otherwise: `d_o <= IDLE_BIT`, go to IDLE, pulse `underrun_o` for 1 cycle.
- Load and accept cannot collide: acceptance requires `hold_full = 0`, and loading requires `hold_full = 1`.
- `frame_o` is registered and set together with the first bit. `pclk_o` is registered and equals `~cnt[2]` in SHIFT, 0 in IDLE.
- Bit order is fixed at load by `LSB_FIRST`. The shift direction is right when `LSB_FIRST = 1`, left otherwise.
- Reset (`rst_i` low at an edge), including mid-byte:
  - State IDLE, `cnt = 0`, `hold_full = 0`; the in-flight byte and the buffered byte are discarded.
  - Outputs: `d_o = IDLE_BIT`, `frame_o = 0`, `pclk_o = 0`, `underrun_o = 0`.
  - `ready_o = 0` while `rst_i` is low, and 1 in the first cycle after release.

## Timing
- Latency from IDLE: byte accepted at edge E; bit 0 is on `d_o` after edge E+1, and bit 7 after edge E+8.
- Sustained throughput: 1 byte per 8 cycles, continuous.
- Streaming: the next byte may be accepted any time during the current byte. `ready_o` stays low from acceptance until that byte is loaded.
- `valid_i` may be held high continuously. `data_i` is sampled only on accepting edges.
- All outputs except `ready_o` are registered.
- `underrun_o` is asserted in the same cycle that `d_o` first returns to `IDLE_BIT`.

## Test plan
- **Single byte.** `LSB_FIRST=1`: accept 0xA5 at edge E. Required response:
  - `d_o` = 1,0,1,0,0,1,0,1 after edges E+1..E+8, then `IDLE_BIT`.
  - `frame_o` high only after E+1.
  - `pclk_o` = 1,1,1,1,0,0,0,0.
  - `underrun_o` pulses after E+9.
- **Back-to-back.** Hold `valid_i` high with 0x3C then 0xC3. Required response:
  - 16 contiguous bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1.
  - `frame_o` pulses 8 cycles apart.
  - `ready_o` low from each accept until that byte loads.
  - A single `underrun_o` after the last bit.
- **MSB first.** `LSB_FIRST=0`, byte 0x81. Required response: `d_o` = 1,0,0,0,0,0,0,1.
- **Idle level.** `IDLE_BIT=1`, no traffic. Required response: `d_o` stays 1, `pclk_o` stays 0, `ready_o` stays 1.
- **Reset mid-byte.** Reset asserted after bit 3 of 0xFF, with 0x55 buffered. Required response:
  - `d_o = IDLE_BIT` next cycle; no further bits.
  - `ready_o = 0` during reset and 1 after release.
  - A new 0x0F transmits cleanly with 2-cycle latency.
- **Loopback.** Connect `d_o`/`frame_o` to a bit-accurate deserializer model and send 256 incrementing bytes. Required response: all received in order, with no underrun until the end.
